// File: rtl/controlador_jogo_if.sv
// Control/status bundle between the memory-game controller and its datapath.
// Latency: none, wires only.
// Backpressure: none; every signal is a level or single-cycle pulse.
interface controlador_jogo_if;
    // status into the controller
    logic       iniciar;
    logic       jogada;
    logic       jogada_correta;
    logic       enderecoIgualRodada;
    logic       fimR;
    logic       meioTM;
    logic       fimTM;
    logic       timeout;
    logic       modo2;
    // enables out of the controller
    logic       zeraR;
    logic       contaR;
    logic       zeraE;
    logic       contaE;
    logic       zeraT;
    logic       contaT;
    logic       zeraTM;
    logic       contaTM;
    logic       registraR;
    logic       registraN;
    logic       gravaM;
    logic       acende_leds;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       vez_jogador;
    logic       nova_jogada;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada, jogada_correta, enderecoIgualRodada, fimR,
               meioTM, fimTM, timeout, modo2,
        output zeraR, contaR, zeraE, contaE, zeraT, contaT, zeraTM, contaTM,
               registraR, registraN, gravaM, acende_leds, pronto, ganhou,
               perdeu, vez_jogador, nova_jogada, db_estado
    );

    modport slave (
        output iniciar, jogada, jogada_correta, enderecoIgualRodada, fimR,
               meioTM, fimTM, timeout, modo2,
        input  zeraR, contaR, zeraE, contaE, zeraT, contaT, zeraTM, contaTM,
               registraR, registraN, gravaM, acende_leds, pronto, ganhou,
               perdeu, vez_jogador, nova_jogada, db_estado
    );
endinterface

// File: rtl/controlador_jogo.sv
// Moore controller sequencing the memory-game datapath (show, play, record, end).
// Latency: outputs are registered and always match the current state; a press takes 3 cycles.
// Backpressure: none; waits in mostra/apaga/espera_*/fim until the datapath status arrives.
// Optional feature: define TIMEOUT_EN to honour the play-timer timeout.
module controlador_jogo (
    input  logic               clock,
    input  logic               reset,
    controlador_jogo_if.master bus
);

    typedef enum logic [3:0] {
        inicial        = 4'h0,
        preparacao     = 4'h1,
        inicia_rodada  = 4'h2,
        mostra         = 4'h3,
        apaga          = 4'h4,
        proximo_mostra = 4'h5,
        fim_mostra     = 4'h6,
        espera_jogada  = 4'h7,
        registra       = 4'h8,
        compara        = 4'h9,
        proxima_jogada = 4'hA,
        prepara_grava  = 4'hB,
        espera_grava   = 4'hC,
        grava          = 4'hD,
        proxima_rodada = 4'hE,
        fim            = 4'hF
    } estado_t;

    typedef enum logic [1:0] {
        causa_nenhuma = 2'd0,
        causa_vitoria = 2'd1,
        causa_erro    = 2'd2,
        causa_timeout = 2'd3
    } causa_t;

    typedef struct packed {
        logic zera_r;
        logic conta_r;
        logic zera_e;
        logic conta_e;
        logic zera_t;
        logic conta_t;
        logic zera_tm;
        logic conta_tm;
        logic registra_r;
        logic registra_n;
        logic grava_m;
        logic acende_leds;
        logic pronto;
        logic ganhou;
        logic perdeu;
        logic vez_jogador;
        logic nova_jogada;
    } ctl_t;

    estado_t estado, estado_nxt;
    causa_t  causa, causa_nxt;
    logic    primeira;   // first round since preparacao: mode 2 still shows it
    ctl_t    ctl;
    logic    tmo;

`ifdef TIMEOUT_EN
    assign tmo = bus.timeout;
`else
    logic unused_timeout;
    assign unused_timeout = bus.timeout;
    assign tmo = 1'b0;
`endif

    // Output pattern of a state; the cause only matters in fim.
    function automatic ctl_t decodifica(input estado_t e, input causa_t c);
        ctl_t o;
        o = '0;
        case (e)
            preparacao:     begin o.zera_r = 1'b1; o.zera_e = 1'b1; o.registra_n = 1'b1; end
            inicia_rodada:  begin o.zera_e = 1'b1; o.zera_tm = 1'b1; end
            mostra:         begin o.acende_leds = 1'b1; o.conta_tm = 1'b1; end
            apaga:          o.conta_tm = 1'b1;
            proximo_mostra: begin o.conta_e = 1'b1; o.zera_tm = 1'b1; end
            fim_mostra:     begin o.zera_e = 1'b1; o.zera_t = 1'b1; end
            espera_jogada:  begin o.conta_t = 1'b1; o.vez_jogador = 1'b1; end
            registra:       o.registra_r = 1'b1;
            proxima_jogada: begin o.conta_e = 1'b1; o.zera_t = 1'b1; end
            prepara_grava:  begin o.conta_e = 1'b1; o.zera_t = 1'b1; end
            espera_grava:   begin o.conta_t = 1'b1; o.vez_jogador = 1'b1; o.nova_jogada = 1'b1; end
            grava:          o.grava_m = 1'b1;
            proxima_rodada: o.conta_r = 1'b1;
            fim: begin
                o.pronto = 1'b1;
                o.ganhou = (c == causa_vitoria);
                o.perdeu = (c == causa_erro) || (c == causa_timeout);
            end
            default: ;
        endcase
`ifndef TIMEOUT_EN
        // the play timer has no consumer when timeouts are off
        o.conta_t = 1'b0;
`endif
        return o;
    endfunction

    // Next state and end-of-game cause from current state and datapath status.
    always_comb begin
        estado_nxt = estado;
        causa_nxt  = causa;
        case (estado)
            inicial:        if (bus.iniciar) estado_nxt = preparacao;
            preparacao: begin
                estado_nxt = inicia_rodada;
                causa_nxt  = causa_nenhuma;
            end
            inicia_rodada:  estado_nxt = (!bus.modo2 || primeira) ? mostra : fim_mostra;
            mostra:         if (bus.meioTM) estado_nxt = apaga;
            apaga:          if (bus.fimTM) estado_nxt = bus.enderecoIgualRodada ? fim_mostra : proximo_mostra;
            proximo_mostra: estado_nxt = mostra;
            fim_mostra:     estado_nxt = espera_jogada;
            espera_jogada: begin
                if (bus.jogada) begin
                    estado_nxt = registra;
                end else if (tmo) begin
                    estado_nxt = fim;
                    causa_nxt  = causa_timeout;
                end
            end
            registra:       estado_nxt = compara;
            compara: begin
                if (!bus.jogada_correta) begin
                    estado_nxt = fim;
                    causa_nxt  = causa_erro;
                end else if (bus.enderecoIgualRodada && bus.fimR) begin
                    estado_nxt = fim;
                    causa_nxt  = causa_vitoria;
                end else if (bus.enderecoIgualRodada && bus.modo2) begin
                    estado_nxt = prepara_grava;
                end else if (bus.enderecoIgualRodada) begin
                    estado_nxt = proxima_rodada;
                end else begin
                    estado_nxt = proxima_jogada;
                end
            end
            proxima_jogada: estado_nxt = espera_jogada;
            prepara_grava:  estado_nxt = espera_grava;
            espera_grava: begin
                if (bus.jogada) begin
                    estado_nxt = grava;
                end else if (tmo) begin
                    estado_nxt = fim;
                    causa_nxt  = causa_timeout;
                end
            end
            grava:          estado_nxt = proxima_rodada;
            proxima_rodada: estado_nxt = inicia_rodada;
            fim:            if (bus.iniciar) estado_nxt = preparacao;
            default:        estado_nxt = inicial;
        endcase
    end

    // State, cause, first-round flag and output registers; reset clears all outputs at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= inicial;
            causa    <= causa_nenhuma;
            primeira <= 1'b1;
            ctl      <= '0;
        end else begin
            estado <= estado_nxt;
            causa  <= causa_nxt;
            ctl    <= decodifica(estado_nxt, causa_nxt);
            if (estado == preparacao)
                primeira <= 1'b1;
            else if (estado == inicia_rodada)
                primeira <= 1'b0;
        end
    end

    assign bus.zeraR       = ctl.zera_r;
    assign bus.contaR      = ctl.conta_r;
    assign bus.zeraE       = ctl.zera_e;
    assign bus.contaE      = ctl.conta_e;
    assign bus.zeraT       = ctl.zera_t;
    assign bus.contaT      = ctl.conta_t;
    assign bus.zeraTM      = ctl.zera_tm;
    assign bus.contaTM     = ctl.conta_tm;
    assign bus.registraR   = ctl.registra_r;
    assign bus.registraN   = ctl.registra_n;
    assign bus.gravaM      = ctl.grava_m;
    assign bus.acende_leds = ctl.acende_leds;
    assign bus.pronto      = ctl.pronto;
    assign bus.ganhou      = ctl.ganhou;
    assign bus.perdeu      = ctl.perdeu;
    assign bus.vez_jogador = ctl.vez_jogador;
    assign bus.nova_jogada = ctl.nova_jogada;
    assign bus.db_estado   = estado;

endmodule

// File: tb/tb_controlador_jogo.sv
// Bench for controlador_jogo: behavioural datapath, game-level event scoreboard.
// Latency: checks press timing (3 cycles) and reset-to-idle without a clock edge.
// Backpressure: none; every wait on the design is cycle-bounded.
module tb_controlador_jogo;

    localparam int EV_SHOW  = 0;
    localparam int EV_GRAVA = 1;
    localparam int EV_FIM   = 2;
    localparam int FIM_GANHOU = 2;
    localparam int FIM_PERDEU = 1;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    controlador_jogo_if bus ();

    controlador_jogo dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];

    // behavioural datapath: round, address and LED-slot counters
    int mR, mE, mTM;
    int last_round = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mR  <= 0;
            mE  <= 0;
            mTM <= 0;
        end else begin
            if (bus.zeraR) mR <= 0; else if (bus.contaR) mR <= mR + 1;
            if (bus.zeraE) mE <= 0; else if (bus.contaE) mE <= mE + 1;
            if (bus.zeraTM) mTM <= 0; else if (bus.contaTM) mTM <= mTM + 1;
        end
    end

    assign bus.enderecoIgualRodada = (mE == mR);
    assign bus.fimR                = (mR == last_round);
    assign bus.meioTM              = (mTM >= 2);
    assign bus.fimTM               = (mTM >= 4);

    logic [16:0] outs;
    assign outs = {bus.zeraR, bus.contaR, bus.zeraE, bus.contaE, bus.zeraT, bus.contaT,
                   bus.zeraTM, bus.contaTM, bus.registraR, bus.registraN, bus.gravaM,
                   bus.acende_leds, bus.pronto, bus.ganhou, bus.perdeu, bus.vez_jogador,
                   bus.nova_jogada};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic got(input int k, input int v);
        ev_t e;
        chk("event_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_val", v, e.val);
        end
    endtask

    // Game rules: which slots are shown, which addresses get recorded, how it ends.
    task automatic push_game(input int m2, input int nr, input int er, input int ep);
        bit done;
        done = 1'b0;
        for (int r = 0; r < nr && !done; r++) begin
            if (m2 == 0 || r == 0)
                for (int a = 0; a <= r; a++) push_ev(EV_SHOW, a);
            for (int p = 0; p <= r && !done; p++)
                if (r == er && p == ep) begin
                    push_ev(EV_FIM, FIM_PERDEU);
                    done = 1'b1;
                end
            if (!done) begin
                if (r == nr - 1) begin
                    push_ev(EV_FIM, FIM_GANHOU);
                    done = 1'b1;
                end else if (m2 != 0) begin
                    push_ev(EV_GRAVA, r + 1);
                end
            end
        end
    endtask

    // monitor: turns DUT outputs into game events and pops the scoreboard
    logic prev_leds = 1'b0, prev_grava = 1'b0, prev_pronto = 1'b0, prev_nova = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.acende_leds && !prev_leds) got(EV_SHOW, mE);
            if (bus.gravaM) begin
                chk("grava_single_cycle", int'(prev_grava), 0);
                chk("nova_jogada_before_grava", int'(prev_nova), 1);
                got(EV_GRAVA, mE);
            end
            if (bus.pronto && !prev_pronto) begin
                chk("fim_estado", int'(bus.db_estado), 15);
                got(EV_FIM, int'({bus.ganhou, bus.perdeu}));
            end
`ifndef TIMEOUT_EN
            if (bus.vez_jogador) chk("contaT_tied_low", int'(bus.contaT), 0);
`endif
        end
        prev_leds   <= bus.acende_leds;
        prev_grava  <= bus.gravaM;
        prev_pronto <= bus.pronto;
        prev_nova   <= bus.nova_jogada;
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_outputs"}, int'(outs), 0);
        chk({tag, "_db_estado"}, int'(bus.db_estado), 0);
    endtask

    task automatic start_game();
        @(negedge clock) bus.iniciar = 1'b1;
        @(negedge clock) bus.iniciar = 1'b0;
    endtask

    task automatic wait_vez();
        int n;
        n = 0;
        while (!bus.vez_jogador && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("wait_vez_jogador", int'(bus.vez_jogador), 1);
    endtask

    task automatic wait_pronto();
        int n;
        n = 0;
        while (!bus.pronto && n < 4000) begin
            @(negedge clock);
            n++;
        end
        chk("wait_pronto", int'(bus.pronto), 1);
    endtask

    task automatic drain_check();
        @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // one button press; the play at (er, ep) is the wrong one
    task automatic press(input int er, input int ep);
        int d;
        bit rec, bad;
        d = $urandom_range(0, 2);
        repeat (d) @(negedge clock);
        rec = bus.nova_jogada;
        bad = !rec && (mR == er) && (mE == ep);
        bus.jogada_correta = !bad;
        bus.jogada = 1'b1;
        @(negedge clock) bus.jogada = 1'b0;
        if (rec) begin
            chk("press_to_grava", int'(bus.db_estado), 13);
        end else begin
            chk("press_to_registra", int'(bus.db_estado), 8);
            @(negedge clock);
            chk("press_to_compara", int'(bus.db_estado), 9);
            if (bad) begin
                @(negedge clock);
                chk("erro_to_fim", int'(bus.db_estado), 15);
            end
        end
    endtask

    task automatic run_game(input int m2, input int nr, input int er, input int ep);
        int n;
        push_game(m2, nr, er, ep);
        bus.modo2   = m2[0];
        bus.timeout = 1'b0;
        last_round  = nr - 1;
        start_game();
        n = 0;
        while (!bus.pronto && n < 4000) begin
            @(negedge clock);
            n++;
            if (bus.vez_jogador) press(er, ep);
        end
        chk("game_ends", int'(bus.pronto), 1);
        drain_check();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int m2, nr, er, ep;
        reset = 1'b1;
        bus.iniciar = 1'b0;
        bus.jogada = 1'b0;
        bus.jogada_correta = 1'b1;
        bus.timeout = 1'b0;
        bus.modo2 = 1'b0;
        #7;
        check_reset_state("reset_init");
        @(negedge clock) reset = 1'b0;
        @(negedge clock);
        chk("idle_db_estado", int'(bus.db_estado), 0);

        // wrong first play, mode 1
        run_game(0, 3, 0, 0);
        // mode 1 win over two rounds
        run_game(0, 2, -1, 0);
        // mode 2: record after each non-final round, later rounds skip presentation
        run_game(1, 3, -1, 0);

`ifdef TIMEOUT_EN
        push_ev(EV_SHOW, 0);
        push_ev(EV_SHOW, 0);
        push_ev(EV_SHOW, 1);
        push_ev(EV_FIM, FIM_PERDEU);
        bus.modo2 = 1'b0;
        last_round = 1;
        start_game();
        wait_vez();
        bus.timeout = 1'b1;
        bus.jogada_correta = 1'b1;
        bus.jogada = 1'b1;
        @(negedge clock);
        bus.jogada = 1'b0;
        bus.timeout = 1'b0;
        chk("timeout_and_jogada_registra", int'(bus.db_estado), 8);
        wait_vez();
        bus.timeout = 1'b1;
        @(negedge clock);
        chk("timeout_to_fim", int'(bus.db_estado), 15);
        chk("timeout_perdeu", int'(bus.perdeu), 1);
        chk("timeout_ganhou", int'(bus.ganhou), 0);
        bus.timeout = 1'b0;
        drain_check();
`else
        push_ev(EV_SHOW, 0);
        push_ev(EV_FIM, FIM_GANHOU);
        bus.modo2 = 1'b0;
        last_round = 0;
        start_game();
        wait_vez();
        bus.timeout = 1'b1;
        repeat (100) @(negedge clock);
        chk("no_timeout_estado", int'(bus.db_estado), 7);
        chk("no_timeout_contaT", int'(bus.contaT), 0);
        bus.timeout = 1'b0;
        bus.jogada_correta = 1'b1;
        bus.jogada = 1'b1;
        @(negedge clock) bus.jogada = 1'b0;
        wait_pronto();
        chk("no_timeout_ganhou", int'(bus.ganhou), 1);
        drain_check();
`endif

        // reset while waiting for a play
        push_ev(EV_SHOW, 0);
        bus.modo2 = 1'b0;
        last_round = 3;
        start_game();
        wait_vez();
        chk("pre_reset_espera", int'(bus.db_estado), 7);
        #2 reset = 1'b1;
        #1;
        check_reset_state("reset_midgame");
        exp_q.delete();
        @(negedge clock);
        check_reset_state("reset_held");
        reset = 1'b0;

        for (int g = 0; g < 20; g++) begin
            m2 = int'($urandom_range(0, 1));
            nr = int'($urandom_range(1, 4));
            if ($urandom_range(0, 2) == 0) begin
                er = -1;
                ep = 0;
            end else begin
                er = int'($urandom_range(0, nr - 1));
                ep = int'($urandom_range(0, er));
            end
            run_game(m2, nr, er, ep);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
